// File: rtl/truth_table_scanner.sv
// Sequential stimulus/capture stage for 3-input truth-table implementations:
// walks {A,B,C} through 0..7, samples Y after a settle delay, and grades the result.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] fail_cnt,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] table_q, table_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [2:0] ff_q, ff_d;

  logic [7:0] diff;
  logic [3:0] fcnt_calc;
  logic [2:0] ff_calc;
  logic       found;

  // Grading logic: popcount of mismatches and lowest mismatching row
  always_comb begin
    diff      = table_q ^ exp_q;
    fcnt_calc = '0;
    ff_calc   = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      fcnt_calc = fcnt_calc + {3'b000, diff[i]};
      if (diff[i] && !found) begin
        ff_calc = 3'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fcnt_d  = fcnt_q;
    ff_d    = ff_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          pass_d  = 1'b0;
          fcnt_d  = '0;
          ff_d    = '0;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == SETTLE_L) begin
          table_d[vec_q] = y_in;
          cnt_d          = '0;
          if (vec_q != 3'd7) vec_d = vec_q + 3'd1;
          else               state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (diff == 8'h00);
        fcnt_d  = fcnt_calc;
        ff_d    = ff_calc;
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fcnt_q  <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fcnt_q  <= fcnt_d;
      ff_q    <= ff_d;
    end
  end

  assign a_out      = vec_q[2];
  assign b_out      = vec_q[1];
  assign c_out      = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign pass       = pass_q;
  assign fail_cnt   = fcnt_q;
  assign first_fail = ff_q;

endmodule
